// File: rtl/msfsm_firing_scheduler.sv
// rtl/msfsm_firing_scheduler.sv - round-robin, one-hot transition fire scheduler for an MSFSM net
// Optional watchdog: define MSFSM_DEADLOCK_DETECT_EN to add the sticky deadlock output.
module msfsm_firing_scheduler #(
  parameter int NUM_PLACES      = 8,
  parameter int NUM_TRANS       = 7,
  parameter logic [NUM_TRANS*NUM_PLACES-1:0] PRESET_MASK = '0,
  parameter int SETTLE_CYCLES   = 1,
  parameter int DEADLOCK_CYCLES = 16,
  localparam int IW = (NUM_TRANS > 1) ? $clog2(NUM_TRANS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_PLACES-1:0] marking,
  input  logic [NUM_TRANS-1:0]  req,
  output logic [NUM_TRANS-1:0]  enabled,
  output logic [NUM_TRANS-1:0]  fire,
  output logic [IW-1:0]         fire_idx,
  output logic                  busy
`ifdef MSFSM_DEADLOCK_DETECT_EN
  ,
  output logic                  deadlock
`endif
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRE   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t               state;
  logic [IW-1:0]        rr_ptr;
  logic [CW-1:0]        settle_cnt;
  logic [NUM_TRANS-1:0] eligible;
  logic                 sel_found;
  logic [IW-1:0]        sel_idx;
  logic [NUM_TRANS-1:0] sel_oh;
  logic [IW:0]          cand;

  // A place outside the preset is treated as marked, so empty presets are always enabled.
  always_comb begin
    enabled = '0;
    for (int t = 0; t < NUM_TRANS; t++)
      enabled[t] = &(marking | ~PRESET_MASK[t*NUM_PLACES +: NUM_PLACES]);
  end

  assign eligible = enabled & req;

  // Scan starting at rr_ptr, wrapping, and take the first eligible transition.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_oh    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_TRANS; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_TRANS))
        cand = cand - (IW+1)'(NUM_TRANS);
      if (!sel_found && eligible[cand[IW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IW-1:0];
      end
    end
    if (sel_found)
      sel_oh[sel_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      fire       <= '0;
      fire_idx   <= '0;
      busy       <= 1'b0;
      rr_ptr     <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            fire     <= sel_oh;
            fire_idx <= sel_idx;
            busy     <= 1'b1;
            state    <= FIRE;
          end
        end
        FIRE: begin
          fire       <= '0;
          rr_ptr     <= (fire_idx == IW'(NUM_TRANS-1)) ? '0 : fire_idx + 1'b1;
          settle_cnt <= CW'(SETTLE_CYCLES-1);
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        default: begin
          fire  <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MSFSM_DEADLOCK_DETECT_EN
  localparam int DW = $clog2(DEADLOCK_CYCLES+1);

  logic [DW-1:0] dl_cnt;

  // Counts idle cycles where something is requested but nothing can fire; deadlock is sticky.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dl_cnt   <= '0;
      deadlock <= 1'b0;
    end else if (req == '0 || (state == IDLE && sel_found)) begin
      dl_cnt <= '0;
    end else if (state == IDLE && dl_cnt != DW'(DEADLOCK_CYCLES)) begin
      dl_cnt <= dl_cnt + 1'b1;
      if (dl_cnt == DW'(DEADLOCK_CYCLES-1))
        deadlock <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_msfsm_firing_scheduler.sv
// tb/tb_msfsm_firing_scheduler.sv - scoreboard bench for msfsm_firing_scheduler
// Covers MSFSM_DEADLOCK_DETECT_EN checks when that macro is defined.
module tb_msfsm_firing_scheduler;

  localparam int NP = 8;
  localparam int NT = 7;
  localparam int SC = 3;
  // t0,t1 share {p0}; t2 needs {p2}; t6 needs {p6}; t3..t5 are source transitions.
  localparam logic [NT*NP-1:0] PM = (56'd1 << 0) | (56'd1 << 8) | (56'd1 << 18) | (56'd1 << 54);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NP-1:0] marking = '0;
  logic [NT-1:0] req = '0;
  logic [NT-1:0] enabled;
  logic [NT-1:0] fire;
  logic [2:0]    fire_idx;
  logic          busy;
`ifdef MSFSM_DEADLOCK_DETECT_EN
  logic          deadlock;
`endif

  msfsm_firing_scheduler #(
    .NUM_PLACES(NP), .NUM_TRANS(NT), .PRESET_MASK(PM),
    .SETTLE_CYCLES(SC), .DEADLOCK_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .marking(marking), .req(req),
    .enabled(enabled), .fire(fire), .fire_idx(fire_idx), .busy(busy)
`ifdef MSFSM_DEADLOCK_DETECT_EN
    , .deadlock(deadlock)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int gap;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_fire = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input int gap);
    exp_t e;
    e.idx = idx;
    e.gap = gap;
    sb.push_back(e);
  endtask

  // Monitor: every fire pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset && fire != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_fire", int'(fire), 0);
      end else begin
        e = sb.pop_front();
        check("fire_onehot", int'(fire), 1 << e.idx);
        check("fire_idx", int'(fire_idx), e.idx);
        if (e.gap >= 0)
          check("fire_gap", cyc - last_fire, e.gap);
      end
      last_fire = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check({name, "_drained"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int bcnt;

    // Reset with everything requested and marked: outputs stay quiet.
    req = '1;
    marking = '1;
    tick(3);
    check("rst_fire", int'(fire), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fire_idx", int'(fire_idx), 0);
`ifdef MSFSM_DEADLOCK_DETECT_EN
    check("rst_deadlock", int'(deadlock), 0);
`endif
    // Full rotation t0..t6 then wrap back to t0, one fire every SC+2 cycles.
    push(0, -1);
    for (int t = 1; t < NT; t++) push(t, SC + 2);
    push(0, SC + 2);
    @(negedge clk);
    reset = 1'b1;
    wait_drain("rotation");
    req = '0;
    tick(SC + 3);
    check("idle_busy", int'(busy), 0);

    // Preset gating: t2 is requested but p2 is empty.
    marking = 8'b1111_1011;
    req = 7'b000_0100;
    #1;
    check("enabled_gated", int'(enabled), 7'b111_1011);
    tick(20);
    push(2, -1);
    marking = '1;
    tick(1);
    check("gated_latency_fire", int'(fire), 7'b000_0100);
    req = '0;
    wait_drain("gated");
    tick(SC + 3);

    // Free-choice conflict on p0: rr_ptr=3 wraps to t0, then alternates.
    push(0, -1);
    push(1, SC + 2);
    push(0, SC + 2);
    push(1, SC + 2);
    req = 7'b000_0011;
    tick(1);
    bcnt = 0;
    for (int i = 0; i < 2 * (SC + 2); i++) begin
      if (busy) bcnt++;
      tick(1);
    end
    check("busy_duty", bcnt, 2 * (SC + 1));
    wait_drain("conflict");
    req = '0;
    tick(SC + 3);

    // Mid-fire reset: t2 is next (rr_ptr=2), reset kills the pulse asynchronously.
    push(2, -1);
    req = '1;
    tick(1);
    #1;
    reset = 1'b0;
    #1;
    check("async_fire_drop", int'(fire), 0);
    check("async_busy_drop", int'(busy), 0);
    check("async_fire_idx", int'(fire_idx), 0);
    wait_drain("pre_reset");
    push(0, -1);
    push(1, SC + 2);
    @(negedge clk);
    reset = 1'b1;
    wait_drain("post_reset");
    req = '0;
    tick(SC + 3);

`ifdef MSFSM_DEADLOCK_DETECT_EN
    // Starved t6: deadlock sets on the 16th idle cycle and survives the eventual fire.
    marking = 8'b1011_1111;
    req = 7'b100_0000;
    tick(15);
    check("deadlock_before", int'(deadlock), 0);
    tick(1);
    check("deadlock_set", int'(deadlock), 1);
    push(6, -1);
    marking = '1;
    wait_drain("deadlock_fire");
    tick(2);
    check("deadlock_sticky", int'(deadlock), 1);
    req = '0;
    tick(SC + 3);
`endif

    check("final_unpopped", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
